// File: rtl/silencer_stepper.sv
// rtl/silencer_stepper.sv - per-transducer duty/phase slew limiter, 2-stage pipeline
// Optional circular phase limiting under macro PHASE_SILENCER_EN.
module silencer_stepper #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      step,
    input  logic [WIDTH-1:0] cycle_s,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] phase_in,
    output logic [WIDTH-1:0] duty_out,
    output logic [WIDTH-1:0] phase_out,
    output logic             dout_valid,
    output logic [15:0]      idx_out
);
    localparam int AW = ((WIDTH > 16) ? WIDTH : 16) + 2;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]      idx;
    logic [WIDTH-1:0] cur_duty [DEPTH];

    logic             s1_valid;
    logic [15:0]      s1_idx;
    logic [15:0]      s1_step;
    logic [WIDTH-1:0] s1_duty_t;
    logic [WIDTH-1:0] s1_phase_t;
    logic [WIDTH-1:0] s1_cur_duty;

    logic [AW-1:0]    step_x;
    logic [AW-1:0]    dt_x, dc_x, d_diff, d_mag;
    logic [AW-1:0]    d_sum;
    logic [WIDTH-1:0] next_duty;
    logic [WIDTH-1:0] next_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (din_valid) begin
            idx <= (idx == 16'(DEPTH - 1)) ? 16'd0 : idx + 16'd1;
        end
    end

    // Stage 1: capture the beat and read the held duty for its index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s1_step     <= '0;
            s1_duty_t   <= '0;
            s1_phase_t  <= '0;
            s1_cur_duty <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_idx      <= idx;
                s1_step     <= step;
                s1_duty_t   <= duty_in;
                s1_phase_t  <= phase_in;
                s1_cur_duty <= cur_duty[idx[IW-1:0]];
            end
        end
    end

    // Duty: unsigned magnitude compare against the full 16-bit step, so any
    // step >= 2^WIDTH always lands on the target.
    always_comb begin
        step_x = AW'(s1_step);
        dt_x   = AW'(s1_duty_t);
        dc_x   = AW'(s1_cur_duty);
        d_diff = dt_x - dc_x;
        d_mag  = d_diff[AW-1] ? (dc_x - dt_x) : d_diff;
        d_sum  = d_diff[AW-1] ? (dc_x - step_x) : (dc_x + step_x);
        if (s1_step == 16'd0 || d_mag <= step_x) begin
            next_duty = s1_duty_t;
        end else begin
            next_duty = d_sum[WIDTH-1:0];
        end
    end

`ifdef PHASE_SILENCER_EN
    logic [WIDTH-1:0] cur_phase [DEPTH];
    logic [WIDTH-1:0] s1_cur_phase;
    logic [WIDTH-1:0] s1_cycle;
    logic [AW-1:0]    cyc_x, half_x, pt_x, pc_x, f_x, b_x, adv_x, p_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cur_phase <= '0;
            s1_cycle     <= '0;
        end else if (din_valid) begin
            s1_cur_phase <= cur_phase[idx[IW-1:0]];
            s1_cycle     <= cycle_s;
        end
    end

    // Shortest circular path; a half-period distance resolves forward.
    always_comb begin
        cyc_x  = AW'(s1_cycle);
        half_x = cyc_x >> 1;
        pt_x   = AW'(s1_phase_t);
        pc_x   = AW'(s1_cur_phase);
        f_x    = (pt_x >= pc_x) ? (pt_x - pc_x) : (pt_x + cyc_x - pc_x);
        b_x    = cyc_x - f_x;
        adv_x  = '0;
        p_sum  = pc_x;
        if (f_x <= half_x) begin
            adv_x = (step_x < f_x) ? step_x : f_x;
            p_sum = pc_x + adv_x;
            if (p_sum >= cyc_x) begin
                p_sum = p_sum - cyc_x;
            end
        end else begin
            adv_x = (step_x < b_x) ? step_x : b_x;
            p_sum = (pc_x >= adv_x) ? (pc_x - adv_x) : (pc_x + cyc_x - adv_x);
        end
        if (s1_step == 16'd0) begin
            next_phase = s1_phase_t;
        end else if (f_x == '0) begin
            next_phase = s1_cur_phase;
        end else begin
            next_phase = p_sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cur_phase[i] <= '0;
            end
        end else if (s1_valid) begin
            cur_phase[s1_idx[IW-1:0]] <= next_phase;
        end
    end
`else
    logic unused_cycle;

    assign unused_cycle = ^cycle_s;
    assign next_phase   = s1_phase_t;
`endif

    // Stage 2: write back and present the limited beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cur_duty[i] <= '0;
            end
            duty_out   <= '0;
            phase_out  <= '0;
            dout_valid <= 1'b0;
            idx_out    <= '0;
        end else begin
            dout_valid <= s1_valid;
            if (s1_valid) begin
                cur_duty[s1_idx[IW-1:0]] <= next_duty;
                duty_out  <= next_duty;
                phase_out <= next_phase;
                idx_out   <= s1_idx;
            end
        end
    end
endmodule

// File: tb/tb_silencer_stepper.sv
// tb/tb_silencer_stepper.sv - directed vector bench for silencer_stepper (DEPTH=4)
module tb_silencer_stepper;
    localparam int WIDTH = 13;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      step = '0;
    logic [WIDTH-1:0] cycle_s = 13'd4096;
    logic             din_valid = 1'b0;
    logic [WIDTH-1:0] duty_in = '0;
    logic [WIDTH-1:0] phase_in = '0;
    logic [WIDTH-1:0] duty_out;
    logic [WIDTH-1:0] phase_out;
    logic             dout_valid;
    logic [15:0]      idx_out;

    silencer_stepper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .cycle_s    (cycle_s),
        .din_valid  (din_valid),
        .duty_in    (duty_in),
        .phase_in   (phase_in),
        .duty_out   (duty_out),
        .phase_out  (phase_out),
        .dout_valid (dout_valid),
        .idx_out    (idx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] st;
        logic [12:0] duty;
        logic [12:0] phase;
        logic [12:0] e_duty;
        logic [12:0] e_phase;
        logic [15:0] e_idx;
    } vec_t;

    vec_t        rows[$];
    int          checks = 0;
    int          errors = 0;
    int          row_no = 0;
    logic [12:0] held_duty = '0;
    logic [12:0] held_phase = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input int st, input int duty, input int phase,
                                input int e_duty, input int e_phase, input int e_idx);
        vec_t r;
        r.v       = v;
        r.st      = 16'(st);
        r.duty    = 13'(duty);
        r.phase   = 13'(phase);
        r.e_duty  = 13'(e_duty);
        r.e_phase = 13'(e_phase);
        r.e_idx   = 16'(e_idx);
        rows.push_back(r);
    endfunction

    // Row k is driven before edge k and its result is visible after edge k+1.
    task automatic run_rows();
        int n;
        n = rows.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k < n) begin
                din_valid = rows[k].v;
                step      = rows[k].st;
                duty_in   = rows[k].duty;
                phase_in  = rows[k].phase;
            end else begin
                din_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k >= 1) begin
                if (rows[k-1].v) begin
                    chk($sformatf("row%0d_valid", row_no), 32'(dout_valid), 32'd1);
                    chk($sformatf("row%0d_duty", row_no), 32'(duty_out), 32'(rows[k-1].e_duty));
                    chk($sformatf("row%0d_phase", row_no), 32'(phase_out), 32'(rows[k-1].e_phase));
                    chk($sformatf("row%0d_idx", row_no), 32'(idx_out), 32'(rows[k-1].e_idx));
                    held_duty  = rows[k-1].e_duty;
                    held_phase = rows[k-1].e_phase;
                end else begin
                    chk($sformatf("row%0d_idle", row_no), 32'(dout_valid), 32'd0);
                    chk($sformatf("row%0d_hold_duty", row_no), 32'(duty_out), 32'(held_duty));
                    chk($sformatf("row%0d_hold_phase", row_no), 32'(phase_out), 32'(held_phase));
                end
                row_no++;
            end
        end
        rows.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        held_duty  = '0;
        held_phase = '0;
    endtask

    initial begin
        #12;
        chk("rst_duty", 32'(duty_out), 32'd0);
        chk("rst_phase", 32'(phase_out), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_idx", 32'(idx_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_valid%0d", i), 32'(dout_valid), 32'd0);
        end

        // Bypass (step 0), an idle gap and index wrap.
        add(1, 0, 10, 1, 10, 1, 0);
        add(1, 0, 20, 2, 20, 2, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 30, 3, 30, 3, 2);
        add(1, 0, 40, 4, 40, 4, 3);
        add(1, 0, 5, 5, 5, 5, 0);
        // Step boundaries: >= 2^WIDTH, |d| == step, |d| == step+1, both directions.
        add(1, 16'h2000, 8191, 0, 8191, 0, 1);
        add(1, 8161, 8191, 0, 8191, 0, 2);
        add(1, 8150, 8191, 0, 8190, 0, 3);
        add(1, 16'hFFFF, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 8186, 0, 1);
        add(1, 8191, 0, 0, 0, 0, 2);
        run_rows();

        // Reset asserted while beat 2 of a frame is on the input.
        pulse_reset();
        step = '0;
        phase_in = '0;
        @(negedge clk);
        din_valid = 1'b1;
        duty_in = 13'd7;
        @(negedge clk);
        duty_in = 13'd8;
        @(negedge clk);
        chk("mid_valid0", 32'(dout_valid), 32'd1);
        chk("mid_duty0", 32'(duty_out), 32'd7);
        chk("mid_idx0", 32'(idx_out), 32'd0);
        duty_in = 13'd9;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_duty", 32'(duty_out), 32'd0);
        chk("mid_rst_idx", 32'(idx_out), 32'd0);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        held_duty  = '0;
        held_phase = '0;

        // Slew up to 1000 in steps of 100 on index 0, then back down.
        for (int f = 0; f < 12; f++) begin
            add(1, 100, 1000, 0, ((f + 1) * 100 < 1000) ? (f + 1) * 100 : 1000, 0, 0);
            add(1, 100, 0, 0, 0, 0, 1);
            add(1, 100, 0, 0, 0, 0, 2);
            add(1, 100, 0, 0, 0, 0, 3);
        end
        for (int f = 0; f < 3; f++) begin
            add(1, 100, 0, 0, 900 - 100 * f, 0, 0);
            add(1, 100, 0, 0, 0, 0, 1);
            add(1, 100, 0, 0, 0, 0, 2);
            add(1, 100, 0, 0, 0, 0, 3);
        end
        run_rows();

`ifdef PHASE_SILENCER_EN
        pulse_reset();
        add(1, 0, 0, 4050, 0, 4050, 0);
        add(1, 0, 0, 50, 0, 50, 1);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 3);
        add(1, 60, 0, 50, 0, 14, 0);
        add(1, 60, 0, 4000, 0, 4086, 1);
        add(1, 3000, 0, 2048, 0, 2048, 2);
        add(1, 100, 0, 2048, 0, 100, 3);
        add(1, 60, 0, 50, 0, 50, 0);
        add(1, 60, 0, 4000, 0, 4026, 1);
        add(1, 3000, 0, 2048, 0, 2048, 2);
        add(1, 100, 0, 2048, 0, 200, 3);
        add(1, 60, 0, 50, 0, 50, 0);
        add(1, 60, 0, 4000, 0, 4000, 1);
        add(1, 3000, 0, 2048, 0, 2048, 2);
        add(1, 100, 0, 2048, 0, 300, 3);
        run_rows();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
